// File: rtl/sobel_gradient_if.sv
`default_nettype none
// sobel_gradient_if: pixel-in / gradient-out valid-ready bundle.
// Signal names keep the block's port names; "slave" is the Sobel side.
interface sobel_gradient_if #(
  parameter int WIDTH_P = 8
);
  logic               valid_i;
  logic               ready_o;
  logic [WIDTH_P-1:0] pixel_i;
  logic               sof_i;
  logic               valid_o;
  logic               ready_i;
  logic [WIDTH_P-1:0] gx_o;
  logic [WIDTH_P-1:0] gy_o;

  modport slave (
    input  valid_i, pixel_i, sof_i, ready_i,
    output ready_o, valid_o, gx_o, gy_o
  );

  modport master (
    output valid_i, pixel_i, sof_i, ready_i,
    input  ready_o, valid_o, gx_o, gy_o
  );
endinterface
`default_nettype wire

// File: rtl/sobel_gradient.sv
`default_nettype none
// sobel_gradient: streaming 3x3 Sobel, two line buffers, emits saturated |Gx|/|Gy|
// for interior pixels through a two-stage pipeline with a global stall enable.
module sobel_gradient #(
  parameter int WIDTH_P  = 8,
  parameter int LINE_W_P = 640
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  sobel_gradient_if.slave  io
);

  localparam int COL_W = (LINE_W_P > 1) ? $clog2(LINE_W_P) : 1;
  localparam int G_W   = WIDTH_P + 3;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_W_P - 1);

  logic                      en;
  logic                      acc;
  logic [COL_W-1:0]          col_q, col_d, eff_col;
  logic [1:0]                row_q, row_d, eff_row;
  logic                      window_valid;

  logic [WIDTH_P-1:0]        lb0 [LINE_W_P];
  logic [WIDTH_P-1:0]        lb1 [LINE_W_P];
  logic [WIDTH_P-1:0]        lb0_rd, lb1_rd;

  logic [WIDTH_P-1:0]        win_q [3][3];
  logic [WIDTH_P-1:0]        win_d [3][3];

  logic signed [G_W-1:0]     gx_raw_d, gy_raw_d, gx_raw_q, gy_raw_q;
  logic                      s1_valid_d, s1_valid_q;
  logic                      valid_o_d, valid_o_q;
  logic [WIDTH_P-1:0]        gx_d, gx_q, gy_d, gy_q;

  function automatic logic signed [G_W-1:0] ext1(input logic [WIDTH_P-1:0] p);
    return $signed({3'b000, p});
  endfunction

  function automatic logic signed [G_W-1:0] ext2(input logic [WIDTH_P-1:0] p);
    return $signed({2'b00, p, 1'b0});
  endfunction

  function automatic logic [WIDTH_P-1:0] sat_abs(input logic signed [G_W-1:0] g);
    logic [G_W-1:0] mag;
    mag = g[G_W-1] ? $unsigned(-g) : $unsigned(g);
    if (|mag[G_W-1:WIDTH_P]) return '1;
    return mag[WIDTH_P-1:0];
  endfunction

  // A start-of-frame pixel is placed at (0,0) regardless of the counters.
  always_comb begin
    en      = io.ready_i | ~valid_o_q;
    acc     = io.valid_i & en;
    eff_row = io.sof_i ? 2'd0 : row_q;
    eff_col = io.sof_i ? '0 : col_q;
    lb0_rd  = lb0[eff_col];
    lb1_rd  = lb1[eff_col];
    window_valid = (eff_row == 2'd2) && (eff_col >= COL_W'(2));

    col_d = col_q;
    row_d = row_q;
    win_d = win_q;
    if (acc) begin
      if (eff_col == LAST_COL) begin
        col_d = '0;
        row_d = (eff_row == 2'd2) ? 2'd2 : eff_row + 2'd1;
      end else begin
        col_d = eff_col + COL_W'(1);
        row_d = eff_row;
      end
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb0_rd;
      win_d[1][2] = lb1_rd;
      win_d[2][2] = io.pixel_i;
    end

    // Gradients are taken over the window as it will look after this pixel.
    gx_raw_d = (ext1(win_d[0][2]) + ext2(win_d[1][2]) + ext1(win_d[2][2]))
             - (ext1(win_d[0][0]) + ext2(win_d[1][0]) + ext1(win_d[2][0]));
    gy_raw_d = (ext1(win_d[2][0]) + ext2(win_d[2][1]) + ext1(win_d[2][2]))
             - (ext1(win_d[0][0]) + ext2(win_d[0][1]) + ext1(win_d[0][2]));

    s1_valid_d = en ? (acc & window_valid) : s1_valid_q;
    valid_o_d  = en ? s1_valid_q : valid_o_q;
    gx_d       = en ? sat_abs(gx_raw_q) : gx_q;
    gy_d       = en ? sat_abs(gy_raw_q) : gy_q;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      col_q      <= '0;
      row_q      <= 2'd0;
      s1_valid_q <= 1'b0;
      gx_raw_q   <= '0;
      gy_raw_q   <= '0;
      valid_o_q  <= 1'b0;
      gx_q       <= '0;
      gy_q       <= '0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      win_q      <= win_d;
      s1_valid_q <= s1_valid_d;
      if (en) begin
        gx_raw_q <= gx_raw_d;
        gy_raw_q <= gy_raw_d;
      end
      valid_o_q  <= valid_o_d;
      gx_q       <= gx_d;
      gy_q       <= gy_d;
    end
  end

  // Line buffers carry no reset; every entry is rewritten before it feeds a window.
  always_ff @(posedge clk_i) begin
    if (acc) begin
      lb0[eff_col] <= lb1_rd;
      lb1[eff_col] <= io.pixel_i;
    end
  end

  assign io.ready_o = en;
  assign io.valid_o = valid_o_q;
  assign io.gx_o    = gx_q;
  assign io.gy_o    = gy_q;

endmodule
`default_nettype wire

// File: tb/tb_sobel_gradient.sv
`default_nettype none
// tb_sobel_gradient: directed frames on an 8-pixel-wide line with hand-computed
// gradient sequences, scoreboarded at the output handshake.
module tb_sobel_gradient;
  localparam int W  = 8;
  localparam int LW = 8;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  sobel_gradient_if #(.WIDTH_P(W)) io ();
  sobel_gradient #(.WIDTH_P(W), .LINE_W_P(LW)) dut (.clk_i(clk), .rstn_i(rstn), .io(io));

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_rx    = 0;
  int          rx_base = 0;
  logic [15:0] exp_q [$];
  logic [7:0]  img [4][8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [15:0] e;
    if (rstn && io.valid_o && io.ready_i) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", io.valid_o, 0);
      end else begin
        e = exp_q.pop_front();
        check("gx", io.gx_o, e[15:8]);
        check("gy", io.gy_o, e[7:0]);
      end
      n_rx++;
    end
  end

  task automatic push(input logic [7:0] gx, input logic [7:0] gy);
    exp_q.push_back({gx, gy});
  endtask

  task automatic send(input logic [7:0] px, input logic sof);
    logic a;
    int   tries;
    tries = 0;
    io.valid_i = 1'b1;
    io.pixel_i = px;
    io.sof_i   = sof;
    do begin
      @(negedge clk);
      a = io.ready_o;
      @(posedge clk);
      #1;
      tries++;
    end while (!a && tries < 100);
    if (!a) check("send_timeout", a, 1);
    io.valid_i = 1'b0;
    io.sof_i   = 1'b0;
  endtask

  // Sends raster indices [start, stop) of img; sof on the first one if asked.
  task automatic stream(input int start, input int stop, input bit use_sof);
    for (int i = start; i < stop; i++) begin
      send(img[i / LW][i % LW], use_sof && (i == start));
    end
  endtask

  task automatic drain(input string tag, input int exp_n);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    repeat (4) @(posedge clk);
    #1;
    check(tag, n_rx - rx_base, exp_n);
    exp_q.delete();
    rx_base = n_rx;
  endtask

  task automatic fill(input int kind);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < LW; c++) begin
        case (kind)
          0:       img[r][c] = 8'd100;
          1:       img[r][c] = (c < 4) ? 8'd0 : 8'd255;
          2:       img[r][c] = (r == 0) ? 8'd0 : 8'd10;
          default: img[r][c] = 8'((r * 37 + c * 53 + 11) & 255);
        endcase
      end
    end
  endtask

  task automatic push_vertical();
    for (int r = 0; r < 2; r++) begin
      for (int c = 1; c <= 6; c++) begin
        push((c == 3 || c == 4) ? 8'd255 : 8'd0, 8'd0);
      end
    end
  endtask

  task automatic push_horizontal();
    for (int c = 0; c < 6; c++) push(8'd0, 8'd40);
    for (int c = 0; c < 6; c++) push(8'd0, 8'd0);
  endtask

  initial begin
    logic [7:0] cap_gx, cap_gy;
    int         t;
    io.valid_i = 1'b0;
    io.pixel_i = '0;
    io.sof_i   = 1'b0;
    io.ready_i = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_valid_o", io.valid_o, 0);
    check("rst_gx", io.gx_o, 0);
    check("rst_gy", io.gy_o, 0);
    check("rst_ready_o", io.ready_o, 1);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Constant image, with a latency probe on the first completing pixel (2,2).
    fill(0);
    for (int i = 0; i < 12; i++) push(8'd0, 8'd0);
    stream(0, 19, 1'b1);
    check("lat_cycle1", io.valid_o, 0);
    @(posedge clk);
    #1;
    check("lat_cycle2", io.valid_o, 1);
    stream(19, 32, 1'b0);
    drain("const_count", 12);

    fill(1);
    push_vertical();
    stream(0, 32, 1'b1);
    drain("vert_count", 12);

    fill(2);
    push_horizontal();
    stream(0, 32, 1'b1);
    drain("horiz_count", 12);

    // Single bright pixel in a 3-row frame, at (1,1) then (1,2).
    fill(0);
    for (int r = 0; r < 4; r++) for (int c = 0; c < LW; c++) img[r][c] = 8'd0;
    img[1][1] = 8'd1;
    push(8'd0, 8'd0); push(8'd2, 8'd0);
    for (int i = 0; i < 4; i++) push(8'd0, 8'd0);
    stream(0, 24, 1'b1);
    drain("dot11_count", 6);
    img[1][1] = 8'd0;
    img[1][2] = 8'd1;
    push(8'd2, 8'd0); push(8'd0, 8'd0); push(8'd2, 8'd0);
    for (int i = 0; i < 3; i++) push(8'd0, 8'd0);
    stream(0, 24, 1'b1);
    drain("dot12_count", 6);

    // Backpressure: stall 5 cycles once the first result is presented.
    fill(1);
    push_vertical();
    fork
      stream(0, 32, 1'b1);
      begin
        t = 0;
        do begin
          @(posedge clk);
          #1;
          t++;
        end while (!io.valid_o && t < 200);
        check("bp_first_valid", io.valid_o, 1);
        io.ready_i = 1'b0;
        cap_gx = io.gx_o;
        cap_gy = io.gy_o;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check("bp_ready_o", io.ready_o, 0);
          check("bp_valid_hold", io.valid_o, 1);
          check("bp_gx_hold", io.gx_o, cap_gx);
          check("bp_gy_hold", io.gy_o, cap_gy);
          @(posedge clk);
          #1;
        end
        io.ready_i = 1'b1;
      end
    join
    drain("bp_count", 12);

    // Partial garbage frame abandoned by sof arriving at column 5 of row 1.
    fill(3);
    stream(0, 13, 1'b1);
    fill(1);
    push_vertical();
    stream(0, 32, 1'b1);
    drain("sof_mid_count", 12);

    // Reset right after a completing pixel; the in-flight result must vanish.
    fill(3);
    stream(0, 19, 1'b1);
    rstn = 1'b0;
    #1;
    check("rst_mid_valid_o", io.valid_o, 0);
    check("rst_mid_ready_o", io.ready_o, 1);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    fill(2);
    push_horizontal();
    stream(0, 32, 1'b0);
    drain("rst_mid_count", 12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/sobel_gradient.md
# sobel_gradient

Streaming Sobel operator that produces the gradient pair consumed by the magnitude stage. Accepts a raster-order pixel stream over valid/ready, keeps two line buffers and a 3x3 window internally, and emits saturated absolute horizontal and vertical gradients (`gx_o`, `gy_o`) for every interior pixel over a valid/ready handshake. Sits between the pixel source and `magnitude`; its outputs connect directly to the magnitude inputs.

## Interface
- `WIDTH_P`, 8: pixel width and output gradient width.
- `LINE_W_P`, 640: image width in pixels, minimum 3.

- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rstn_i`  in  1  reset; one clock, asynchronous, active-low.
- `valid_i`  in  1  input pixel valid.
- `ready_o`  out  1  block can accept a pixel this cycle.
- `pixel_i`  in  WIDTH_P  unsigned pixel.
- `sof_i`  in  1  start of frame; qualified by the input handshake.
- `valid_o`  out  1  `gx_o`/`gy_o` valid.
- `ready_i`  in  1  downstream accepts the output this cycle.
- `gx_o`  out  WIDTH_P  |Gx|, saturated.
- `gy_o`  out  WIDTH_P  |Gy|, saturated.

## Operation
- Accept: `acc = valid_i & ready_o`. All line-buffer, window and counter updates happen only on `acc`.
- Counters:
  - `col` runs 0..LINE_W_P-1 and wraps to 0.
  - `row` increments on `col` wrap and saturates at 2.
  - An accepted pixel with `sof_i=1` is treated as (row 0, col 0), so the next pixel is (0, 1). This overrides the current counter values.
- Line buffers:
  - Two buffers `lb0` and `lb1`, each LINE_W_P x WIDTH_P; `lb0` holds the older row.
  - On `acc`, read `lb0[col]` and `lb1[col]`, then write `lb0[col] <= lb1[col]` and `lb1[col] <= pixel_i`.
  - Buffer contents are not reset.
- Window:
  - On `acc`, the 3x3 window `p[r][c]` shifts left by one column.
  - The new right column is `p[0][2]=lb0[col]`, `p[1][2]=lb1[col]`, `p[2][2]=pixel_i`.
  - Row 0 is the oldest row; column 2 is the newest column.
- Window valid: an accepted pixel at (row, col) completes a window only when `row==2 && col>=2`. Border pixels produce no output.
  - Output count per frame is (H-2)*(LINE_W_P-2).
  - Windows never span a line wrap.
- Arithmetic (signed, WIDTH_P+3 bits, no overflow possible):
  - `Gx = (p02 + 2*p12 + p22) - (p00 + 2*p10 + p20)`
  - `Gy = (p20 + 2*p21 + p22) - (p00 + 2*p01 + p02)`
  - Each output is `min(|G|, 2^WIDTH_P - 1)`.
- Pipeline: two stages under a global enable `en = ready_i | ~valid_o`, with `ready_o = en`.
  - Stage 1 (on `en`): `s1_valid <= acc & window_valid`; register raw `Gx` and `Gy`.
  - Stage 2 (on `en`): `valid_o <= s1_valid`; register the saturated absolute values into `gx_o`/`gy_o`.
  - When `en=0`, all pipeline state, counters and buffers hold.

## Timing
- Reset values: `valid_o=0`, `gx_o=0`, `gy_o=0`, `s1_valid=0`, `col=0`, `row=0`, window=0.
  - `ready_o` is 1 while in reset and afterwards, until the first output stalls.
- Latency: a result appears on `valid_o` 2 cycles after acceptance of the completing pixel, with no backpressure.
- Throughput: one pixel per cycle while `ready_i=1`.
- Backpressure: when `valid_o=1 & ready_i=0`:
  - `ready_o=0` in the same cycle (combinational from `ready_i` and `valid_o`).
  - `gx_o`, `gy_o` and `valid_o` stay stable until the handshake completes.
  - No pixel and no result is dropped or duplicated.
- Bubbles: while `valid_o=0`, `en=1`, so bubbles drain and `ready_o` does not drop.
- Simultaneous `sof_i` and `col==LINE_W_P-1`: `sof_i` wins; `row` becomes 0.
- Reset mid-frame: in-flight results are discarded and counters return to (0, 0). The first post-reset output requires two full new lines.
- `sof_i` with `valid_i=0` has no effect.

## Test plan
- Reset → all outputs 0 and `ready_o=1`. Then a constant 100 image (LINE_W_P=8, H=4) → exactly 12 outputs, all `gx_o=gy_o=0`.
- Vertical edge (LINE_W_P=8): columns 0-3 =0, columns 4-7 =255, 4 rows → for centre columns 3 and 4, `gx_o=255` (raw 1020, saturated) and `gy_o=0`. All other outputs are 0.
- Horizontal edge: row 0 =0, rows 1-3 =10 → first output row has `gy_o=40` and `gx_o=0`. Second output row has `gy_o=0`.
- Single bright pixel value 1 at (1,1) in a 3x3 image → one output: `gx_o=0`, `gy_o=0`. Moving it to (1,2) gives `gx_o=2`.
- Backpressure: hold `ready_i=0` for 5 cycles while streaming → `ready_o=0` during the stall, output stable, and the full result sequence matches the golden model.
- `sof_i` asserted mid-line at col 5, and `rstn_i` pulsed mid-frame → no outputs until the 3rd row of the new frame reaches col 2, then the results are correct.
